mem_access_ctrl: RTL and testbench

Memory-stage sequencer for the pipelined RV32I core: it takes the MEM-stage load/store request decoded by the control unit (`MemReadM`, `MemWriteM`, 3-bit `modeAddrM`) and drives a word-wide data-memory bus through a req/ack handshake.

- Misaligned half/word accesses are split into two bus beats.
- Sub-word loads are extracted and sign- or zero-extended.
- `StallMem` freezes the pipeline until the access completes.

---
 rtl/mem_access_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: drives a word-wide req/ack data bus,
// splitting misaligned accesses into two beats and extending sub-word loads.
module mem_access_ctrl #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            modeAddrM,
  input  logic [DATA_WIDTH-1:0] AddrM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallMem,
  output logic                  ErrM,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [DATA_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_be,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  localparam int unsigned NLANES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, DONE} state_t;

  state_t                  state;
  logic [2:0]              mode_q;
  logic [1:0]              off_q;
  logic                    split_q;
  logic [NLANES-1:0]       be_hi_q;
  logic [DATA_WIDTH-1:0]   wdata_hi_q;
  logic [DATA_WIDTH-1:0]   r1_q;

  logic                    req_any;
  logic                    uns_mode;
  logic                    mode_ok;
  logic                    acc_valid;
  logic                    acc_illegal;
  logic [1:0]              off;
  logic [NLANES-1:0]       mask;
  logic                    split_c;
  logic [2*NLANES-1:0]     be_wide;
  logic [2*DATA_WIDTH-1:0] wdata_wide;
  logic [2*DATA_WIDTH-1:0] rd_wide;
  logic [DATA_WIDTH-1:0]   raw;
  logic [DATA_WIDTH-1:0]   load_c;

  // Request decode and lane placement for both beats of a possible split
  always_comb begin
    req_any     = MemReadM | MemWriteM;
    uns_mode    = (modeAddrM == 3'b100) | (modeAddrM == 3'b101);
    mode_ok     = (modeAddrM != 3'b000) & (modeAddrM <= 3'b101);
    acc_valid   = req_any & mode_ok & ~(MemWriteM & uns_mode);
    acc_illegal = req_any & ((modeAddrM >= 3'b110) | (MemWriteM & uns_mode));
    off         = AddrM[1:0];
    case (modeAddrM)
      3'b001:         mask = 4'b1111;
      3'b010, 3'b100: mask = 4'b0011;
      3'b011, 3'b101: mask = 4'b0001;
      default:        mask = 4'b0000;
    endcase
    split_c    = ((mask == 4'b1111) & (off != 2'd0)) | ((mask == 4'b0011) & (off == 2'd3));
    be_wide    = {{NLANES{1'b0}}, mask} << off;
    wdata_wide = {{DATA_WIDTH{1'b0}}, WriteDataM} << {off, 3'b000};
  end

  // Load assembly: {second word, first word} shifted down by the byte offset
  always_comb begin
    rd_wide = (state == BEAT2) ? {bus_rdata, r1_q} : {{DATA_WIDTH{1'b0}}, bus_rdata};
    raw     = DATA_WIDTH'(rd_wide >> {off_q, 3'b000});
    case (mode_q)
      3'b010:  load_c = {{(DATA_WIDTH-16){raw[15]}}, raw[15:0]};
      3'b011:  load_c = {{(DATA_WIDTH-8){raw[7]}}, raw[7:0]};
      3'b100:  load_c = {{(DATA_WIDTH-16){1'b0}}, raw[15:0]};
      3'b101:  load_c = {{(DATA_WIDTH-8){1'b0}}, raw[7:0]};
      default: load_c = raw;
    endcase
  end

  assign StallMem = ~rst & (((state == IDLE) & acc_valid) | (state == BEAT1) | (state == BEAT2));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode_q     <= 3'b000;
      off_q      <= 2'd0;
      split_q    <= 1'b0;
      be_hi_q    <= '0;
      wdata_hi_q <= '0;
      r1_q       <= '0;
      ReadDataM  <= '0;
      ErrM       <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
    end else begin
      ErrM <= 1'b0;
      case (state)
        IDLE: begin
          if (acc_valid) begin
            state      <= BEAT1;
            mode_q     <= modeAddrM;
            off_q      <= off;
            split_q    <= split_c;
            be_hi_q    <= be_wide[2*NLANES-1:NLANES];
            wdata_hi_q <= wdata_wide[2*DATA_WIDTH-1:DATA_WIDTH];
            bus_req    <= 1'b1;
            bus_we     <= MemWriteM;
            bus_addr   <= {AddrM[DATA_WIDTH-1:2], 2'b00};
            bus_be     <= be_wide[NLANES-1:0];
            bus_wdata  <= wdata_wide[DATA_WIDTH-1:0];
          end else if (acc_illegal) begin
            ErrM <= 1'b1;
          end
        end
        BEAT1: begin
          if (bus_ack) begin
            r1_q <= bus_rdata;
            if (split_q) begin
              // bus_req stays high; second beat targets the next word
              state     <= BEAT2;
              bus_addr  <= bus_addr + DATA_WIDTH'(4);
              bus_be    <= be_hi_q;
              bus_wdata <= wdata_hi_q;
            end else begin
              state   <= DONE;
              bus_req <= 1'b0;
              if (!bus_we) ReadDataM <= load_c;
            end
          end
        end
        BEAT2: begin
          if (bus_ack) begin
            state   <= DONE;
            bus_req <= 1'b0;
            if (!bus_we) ReadDataM <= load_c;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        MemReadM;
  logic        MemWriteM;
  logic [2:0]  modeAddrM;
  logic [31:0] AddrM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallMem;
  logic        ErrM;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks;
  int failures;

  mem_access_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .modeAddrM(modeAddrM),
    .AddrM(AddrM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallMem(StallMem), .ErrM(ErrM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] m,
                       input logic [31:0] a, input logic [31:0] d);
    MemReadM = rd; MemWriteM = wr; modeAddrM = m; AddrM = a; WriteDataM = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    bus_ack = 1'b0; bus_rdata = 32'h0;
    tick(); tick();
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL rst_req got %b exp 0", bus_req); end
    checks++; if (bus_we !== 1'b0) begin failures++; $display("FAIL rst_we got %b exp 0", bus_we); end
    checks++; if (bus_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got %h exp 0", bus_addr); end
    checks++; if (bus_be !== 4'h0) begin failures++; $display("FAIL rst_be got %b exp 0", bus_be); end
    checks++; if (bus_wdata !== 32'h0) begin failures++; $display("FAIL rst_wdata got %h exp 0", bus_wdata); end
    checks++; if (ReadDataM !== 32'h0) begin failures++; $display("FAIL rst_rdata got %h exp 0", ReadDataM); end
    checks++; if (ErrM !== 1'b0) begin failures++; $display("FAIL rst_err got %b exp 0", ErrM); end
    drive(1'b1, 1'b0, 3'b001, 32'h100, 32'h0); #1;
    checks++; if (StallMem !== 1'b0) begin failures++; $display("FAIL rst_stall got %b exp 0", StallMem); end
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_aligned_load();
    drive(1'b1, 1'b0, 3'b001, 32'h100, 32'h0); #1;
    checks++; if (StallMem !== 1'b1) begin failures++; $display("FAIL lw_stall_t0 got %b exp 1", StallMem); end
    tick();
    checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL lw_req got %b exp 1", bus_req); end
    checks++; if (bus_addr !== 32'h100) begin failures++; $display("FAIL lw_addr got %h exp 100", bus_addr); end
    checks++; if (bus_be !== 4'b1111) begin failures++; $display("FAIL lw_be got %b exp 1111", bus_be); end
    checks++; if (bus_we !== 1'b0) begin failures++; $display("FAIL lw_we got %b exp 0", bus_we); end
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF; #1;
    checks++; if (StallMem !== 1'b1) begin failures++; $display("FAIL lw_stall_t1 got %b exp 1", StallMem); end
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0; #1;
    checks++; if (StallMem !== 1'b0) begin failures++; $display("FAIL lw_stall_done got %b exp 0", StallMem); end
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL lw_req_done got %b exp 0", bus_req); end
    checks++; if (ReadDataM !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data got %h exp deadbeef", ReadDataM); end
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_byte_store();
    drive(1'b0, 1'b1, 3'b011, 32'h203, 32'h123456AB); #1;
    checks++; if (StallMem !== 1'b1) begin failures++; $display("FAIL sb_stall got %b exp 1", StallMem); end
    tick();
    checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL sb_req got %b exp 1", bus_req); end
    checks++; if (bus_we !== 1'b1) begin failures++; $display("FAIL sb_we got %b exp 1", bus_we); end
    checks++; if (bus_addr !== 32'h200) begin failures++; $display("FAIL sb_addr got %h exp 200", bus_addr); end
    checks++; if (bus_be !== 4'b1000) begin failures++; $display("FAIL sb_be got %b exp 1000", bus_be); end
    checks++; if (bus_wdata !== 32'hAB000000) begin failures++; $display("FAIL sb_wdata got %h exp ab000000", bus_wdata); end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0; #1;
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL sb_req_done got %b exp 0", bus_req); end
    checks++; if (ReadDataM !== 32'hDEADBEEF) begin failures++; $display("FAIL sb_keeps_rdata got %h exp deadbeef", ReadDataM); end
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_misaligned_load();
    drive(1'b1, 1'b0, 3'b001, 32'h1002, 32'h0);
    tick();
    checks++; if (bus_addr !== 32'h1000) begin failures++; $display("FAIL mlw_addr1 got %h exp 1000", bus_addr); end
    checks++; if (bus_be !== 4'b1100) begin failures++; $display("FAIL mlw_be1 got %b exp 1100", bus_be); end
    bus_ack = 1'b1; bus_rdata = 32'h44332211;
    tick();
    bus_rdata = 32'h88776655; #1;
    checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL mlw_req2 got %b exp 1", bus_req); end
    checks++; if (bus_addr !== 32'h1004) begin failures++; $display("FAIL mlw_addr2 got %h exp 1004", bus_addr); end
    checks++; if (bus_be !== 4'b0011) begin failures++; $display("FAIL mlw_be2 got %b exp 0011", bus_be); end
    checks++; if (StallMem !== 1'b1) begin failures++; $display("FAIL mlw_stall2 got %b exp 1", StallMem); end
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0; #1;
    checks++; if (StallMem !== 1'b0) begin failures++; $display("FAIL mlw_stall_done got %b exp 0", StallMem); end
    checks++; if (ReadDataM !== 32'h66554433) begin failures++; $display("FAIL mlw_data got %h exp 66554433", ReadDataM); end
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_half_loads();
    int stall_cycles;
    stall_cycles = 0;
    // lh with a two-cycle ack delay
    drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0); #1;
    if (StallMem === 1'b1) stall_cycles++;
    for (int c = 0; c < 3; c++) begin
      tick();
      bus_ack = (c == 2); bus_rdata = (c == 2) ? 32'h00008001 : 32'h0; #1;
      if (StallMem === 1'b1) stall_cycles++;
      checks++; if (bus_addr !== 32'h10) begin failures++; $display("FAIL lh_addr_c%0d got %h exp 10", c, bus_addr); end
    end
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0; #1;
    if (StallMem === 1'b1) stall_cycles++;
    checks++; if (stall_cycles !== 4) begin failures++; $display("FAIL lh_stall_len got %0d exp 4", stall_cycles); end
    checks++; if (ReadDataM !== 32'hFFFF8001) begin failures++; $display("FAIL lh_data got %h exp ffff8001", ReadDataM); end
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    // lhu zero-wait
    drive(1'b1, 1'b0, 3'b100, 32'h10, 32'h0);
    tick();
    checks++; if (bus_be !== 4'b0011) begin failures++; $display("FAIL lhu_be got %b exp 0011", bus_be); end
    bus_ack = 1'b1; bus_rdata = 32'h00008001;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0; #1;
    checks++; if (ReadDataM !== 32'h00008001) begin failures++; $display("FAIL lhu_data got %h exp 00008001", ReadDataM); end
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_wrap_store();
    drive(1'b0, 1'b1, 3'b001, 32'hFFFFFFFE, 32'hCAFEBABE);
    tick();
    checks++; if (bus_addr !== 32'hFFFFFFFC) begin failures++; $display("FAIL sww_addr1 got %h exp fffffffc", bus_addr); end
    checks++; if (bus_be !== 4'b1100) begin failures++; $display("FAIL sww_be1 got %b exp 1100", bus_be); end
    checks++; if (bus_wdata !== 32'hBABE0000) begin failures++; $display("FAIL sww_wdata1 got %h exp babe0000", bus_wdata); end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0; #1;
    checks++; if (bus_addr !== 32'h0) begin failures++; $display("FAIL sww_addr2 got %h exp 0", bus_addr); end
    checks++; if (bus_be !== 4'b0011) begin failures++; $display("FAIL sww_be2 got %b exp 0011", bus_be); end
    checks++; if (bus_wdata !== 32'h0000CAFE) begin failures++; $display("FAIL sww_wdata2 got %h exp 0000cafe", bus_wdata); end
    tick();
    checks++; if (bus_addr !== 32'h0 || bus_req !== 1'b1) begin failures++; $display("FAIL sww_hold got addr %h req %b exp 0/1", bus_addr, bus_req); end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0; #1;
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL sww_req_done got %b exp 0", bus_req); end
    checks++; if (ReadDataM !== 32'h00008001) begin failures++; $display("FAIL sww_keeps_rdata got %h exp 00008001", ReadDataM); end
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_illegal();
    drive(1'b1, 1'b0, 3'b000, 32'h40, 32'h0); #1;
    checks++; if (StallMem !== 1'b0) begin failures++; $display("FAIL nop_stall got %b exp 0", StallMem); end
    tick();
    checks++; if (bus_req !== 1'b0 || ErrM !== 1'b0) begin failures++; $display("FAIL nop_req_err got req %b err %b exp 0/0", bus_req, ErrM); end
    drive(1'b0, 1'b1, 3'b101, 32'h40, 32'h55); #1;
    checks++; if (StallMem !== 1'b0) begin failures++; $display("FAIL ill_stall got %b exp 0", StallMem); end
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checks++; if (ErrM !== 1'b1) begin failures++; $display("FAIL ill_err got %b exp 1", ErrM); end
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL ill_req got %b exp 0", bus_req); end
    tick();
    checks++; if (ErrM !== 1'b0) begin failures++; $display("FAIL ill_err_pulse got %b exp 0", ErrM); end
    drive(1'b1, 1'b0, 3'b111, 32'h40, 32'h0);
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checks++; if (ErrM !== 1'b1) begin failures++; $display("FAIL ill_mode7_err got %b exp 1", ErrM); end
    tick();
  endtask

  task automatic test_reset_midbeat();
    drive(1'b1, 1'b0, 3'b001, 32'h1002, 32'h0);
    tick();
    bus_ack = 1'b1; bus_rdata = 32'h11111111;
    tick();
    bus_ack = 1'b0;
    checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h1004) begin failures++; $display("FAIL rmb_beat2 got req %b addr %h exp 1/1004", bus_req, bus_addr); end
    rst = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    rst = 1'b0; #1;
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL rmb_req got %b exp 0", bus_req); end
    checks++; if (StallMem !== 1'b0) begin failures++; $display("FAIL rmb_stall got %b exp 0", StallMem); end
    checks++; if (ReadDataM !== 32'h0) begin failures++; $display("FAIL rmb_rdata got %h exp 0", ReadDataM); end
    // Back in IDLE: a fresh byte load must start immediately
    drive(1'b1, 1'b0, 3'b011, 32'h21, 32'h0); #1;
    checks++; if (StallMem !== 1'b1) begin failures++; $display("FAIL rmb_idle_stall got %b exp 1", StallMem); end
    tick();
    checks++; if (bus_be !== 4'b0010 || bus_addr !== 32'h20) begin failures++; $display("FAIL rmb_lb_beat got be %b addr %h exp 0010/20", bus_be, bus_addr); end
    bus_ack = 1'b1; bus_rdata = 32'h0000A500;
    tick();
    bus_ack = 1'b0; #1;
    checks++; if (ReadDataM !== 32'hFFFFFFA5) begin failures++; $display("FAIL rmb_lb_data got %h exp ffffffa5", ReadDataM); end
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_aligned_load();
    test_byte_store();
    test_misaligned_load();
    test_half_loads();
    test_wrap_store();
    test_illegal();
    test_reset_midbeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
